// File: rtl/bp_assoc_cache.sv
// Set-associative branch-history cache with tree pseudo-LRU replacement.
// Two combinational lookup ports and one registered saturating-update port.
module bp_assoc_cache #(
    parameter int AWIDTH = 30,
    parameter int DWIDTH = 2,
    parameter int LINES  = 8,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] ra0,
    output logic [DWIDTH-1:0] dout0,
    output logic              hit0,
    output logic              taken0,
    input  logic [AWIDTH-1:0] ra1,
    output logic [DWIDTH-1:0] dout1,
    output logic              hit1,
    output logic              taken1,
    input  logic [AWIDTH-1:0] ua,
    input  logic              utaken,
    input  logic              uv,
    input  logic              flush,
    output logic              upd_hit,
    output logic              upd_evict
);

    localparam int IW = $clog2(LINES);
    localparam int TW = AWIDTH - IW;
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;

    localparam logic [DWIDTH-1:0] CMAX = '1;
    localparam logic [DWIDTH-1:0] WK_T = DWIDTH'(1) << (DWIDTH - 1);
    localparam logic [DWIDTH-1:0] WK_N = WK_T - DWIDTH'(1);

    logic [WAYS-1:0]   vld  [LINES];
    logic [TW-1:0]     tg   [LINES][WAYS];
    logic [DWIDTH-1:0] ct   [LINES][WAYS];
    logic [PW-1:0]     plru [LINES];

    logic [AWIDTH-1:0] ra [2];
    assign ra[0] = ra0;
    assign ra[1] = ra1;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [IW-1:0]     idx;
        logic [TW-1:0]     tag;
        logic              h;
        logic [DWIDTH-1:0] d;
        assign idx = ra[p][IW-1:0];
        assign tag = ra[p][AWIDTH-1:IW];
        // Scan high to low so the lowest matching way wins.
        always_comb begin
            h = 1'b0;
            d = '0;
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (vld[idx][w] && tg[idx][w] == tag) begin
                    h = 1'b1;
                    d = ct[idx][w];
                end
            end
        end
    end

    assign hit0   = g_rd[0].h;
    assign dout0  = g_rd[0].d;
    assign taken0 = hit0 & dout0[DWIDTH-1];
    assign hit1   = g_rd[1].h;
    assign dout1  = g_rd[1].d;
    assign taken1 = hit1 & dout1[DWIDTH-1];

    logic              q_v;
    logic [AWIDTH-1:0] q_a;
    logic              q_t;

    logic [IW-1:0]     q_idx;
    logic [TW-1:0]     q_tag;
    logic              q_hit;
    logic [WW-1:0]     q_hw;
    logic              has_inv;
    logic [WW-1:0]     inv_way;
    logic [WW-1:0]     plru_way;
    logic [WW-1:0]     q_way;
    logic [DWIDTH-1:0] cur_ct;
    logic [DWIDTH-1:0] new_ct;
    logic [PW-1:0]     cur_p;
    logic [PW-1:0]     nxt_p;

    assign q_idx = q_a[IW-1:0];
    assign q_tag = q_a[AWIDTH-1:IW];
    assign cur_p = plru[q_idx];

    always_comb begin
        q_hit   = 1'b0;
        q_hw    = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vld[q_idx][w] && tg[q_idx][w] == q_tag) begin
                q_hit = 1'b1;
                q_hw  = WW'(w);
            end
            if (!vld[q_idx][w]) begin
                has_inv = 1'b1;
                inv_way = WW'(w);
            end
        end
    end

    // pLRU bits point at the victim; each access flips them away.
    if (WAYS == 4) begin : g_p4
        assign plru_way = cur_p[0] ? {1'b1, cur_p[2]}
                                   : {1'b0, cur_p[1]};
        always_comb begin
            nxt_p    = cur_p;
            nxt_p[0] = ~q_way[1];
            if (q_way[1]) nxt_p[2] = ~q_way[0];
            else          nxt_p[1] = ~q_way[0];
        end
    end else if (WAYS == 2) begin : g_p2
        assign plru_way = cur_p[0];
        assign nxt_p    = ~q_way;
    end else begin : g_p1
        assign plru_way = 1'b0;
        assign nxt_p    = cur_p;
    end

    assign q_way  = q_hit ? q_hw : (has_inv ? inv_way : plru_way);
    assign cur_ct = ct[q_idx][q_hw];

    always_comb begin
        new_ct = q_t ? WK_T : WK_N;
        if (q_hit) begin
            if (q_t) new_ct = (cur_ct == CMAX) ? cur_ct : cur_ct + DWIDTH'(1);
            else     new_ct = (cur_ct == '0)   ? cur_ct : cur_ct - DWIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < LINES; l++) begin
                vld[l]  <= '0;
                plru[l] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tg[l][w] <= '0;
                    ct[l][w] <= '0;
                end
            end
            q_v       <= 1'b0;
            q_a       <= '0;
            q_t       <= 1'b0;
            upd_hit   <= 1'b0;
            upd_evict <= 1'b0;
        end else if (flush) begin
            for (int l = 0; l < LINES; l++) begin
                vld[l]  <= '0;
                plru[l] <= '0;
            end
            q_v       <= 1'b0;
            upd_hit   <= 1'b0;
            upd_evict <= 1'b0;
        end else begin
            q_v       <= uv;
            q_a       <= ua;
            q_t       <= utaken;
            upd_hit   <= q_v & q_hit;
            upd_evict <= q_v & ~q_hit & vld[q_idx][q_way];
            if (q_v) begin
                vld[q_idx][q_way] <= 1'b1;
                tg[q_idx][q_way]  <= q_tag;
                ct[q_idx][q_way]  <= new_ct;
                plru[q_idx]       <= nxt_p;
            end
        end
    end

endmodule

// File: tb/tb_bp_assoc_cache.sv
// Directed and random checks of bp_assoc_cache against an LRU-set model.
module tb_bp_assoc_cache;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] ra0 = '0;
    logic [29:0] ra1 = '0;
    logic [29:0] ua = '0;
    logic        utaken = 1'b0;
    logic        uv = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  dout0, dout1;
    logic        hit0, hit1, taken0, taken1;
    logic        upd_hit, upd_evict;

    int checks = 0;
    int errors = 0;

    bp_assoc_cache #(
        .AWIDTH(30), .DWIDTH(2), .LINES(8), .WAYS(2)
    ) dut (
        .clk(clk), .reset(reset),
        .ra0(ra0), .dout0(dout0), .hit0(hit0), .taken0(taken0),
        .ra1(ra1), .dout1(dout1), .hit1(hit1), .taken1(taken1),
        .ua(ua), .utaken(utaken), .uv(uv), .flush(flush),
        .upd_hit(upd_hit), .upd_evict(upd_evict)
    );

    always #5 clk = ~clk;

    // Model: two ways per set, true LRU (same as tree pLRU for two ways).
    logic        mv   [8][2];
    logic [26:0] mtag [8][2];
    int          mcnt [8][2];
    int          mru  [8];

    logic        pend_v;
    logic [29:0] pend_a;
    logic        pend_t;
    logic        exp_uh, exp_ue;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear(input logic all);
        for (int l = 0; l < 8; l++) begin
            mru[l] = 0;
            for (int w = 0; w < 2; w++) begin
                mv[l][w] = 1'b0;
                if (all) begin
                    mtag[l][w] = '0;
                    mcnt[l][w] = 0;
                end
            end
        end
        pend_v = 1'b0;
        exp_uh = 1'b0;
        exp_ue = 1'b0;
    endtask

    task automatic m_look(input logic [29:0] a, output logic h, output int d);
        int s;
        s = int'(a[2:0]);
        h = 1'b0;
        d = 0;
        for (int w = 1; w >= 0; w--)
            if (mv[s][w] && mtag[s][w] == a[29:3]) begin
                h = 1'b1;
                d = mcnt[s][w];
            end
    endtask

    task automatic m_commit(input logic [29:0] a, input logic t,
                            output logic uh, output logic ue);
        int s, w;
        s  = int'(a[2:0]);
        w  = -1;
        uh = 1'b0;
        ue = 1'b0;
        for (int i = 1; i >= 0; i--)
            if (mv[s][i] && mtag[s][i] == a[29:3]) w = i;
        if (w >= 0) begin
            uh = 1'b1;
            if (t) mcnt[s][w] = (mcnt[s][w] < 3) ? mcnt[s][w] + 1 : 3;
            else   mcnt[s][w] = (mcnt[s][w] > 0) ? mcnt[s][w] - 1 : 0;
        end else begin
            if (!mv[s][0])      w = 0;
            else if (!mv[s][1]) w = 1;
            else                w = 1 - mru[s];
            ue = mv[s][w];
            mv[s][w]   = 1'b1;
            mtag[s][w] = a[29:3];
            mcnt[s][w] = t ? 2 : 1;
        end
        mru[s] = w;
    endtask

    task automatic cyc(input logic v, input logic [29:0] a, input logic t,
                       input logic fl, input logic [29:0] r0,
                       input logic [29:0] r1);
        logic h, uh, ue;
        int   d;
        uv = v; ua = a; utaken = t; flush = fl; ra0 = r0; ra1 = r1;
        #1;
        m_look(r0, h, d);
        chk("hit0", 32'(hit0), 32'(h));
        chk("dout0", 32'(dout0), 32'(d));
        chk("taken0", 32'(taken0), 32'(h && d >= 2));
        m_look(r1, h, d);
        chk("hit1", 32'(hit1), 32'(h));
        chk("dout1", 32'(dout1), 32'(d));
        chk("taken1", 32'(taken1), 32'(h && d >= 2));
        @(posedge clk);
        if (fl) begin
            m_clear(1'b0);
        end else begin
            uh = 1'b0;
            ue = 1'b0;
            if (pend_v) m_commit(pend_a, pend_t, uh, ue);
            exp_uh = uh;
            exp_ue = ue;
            pend_v = v;
            pend_a = a;
            pend_t = t;
        end
        #1;
        chk("upd_hit", 32'(upd_hit), 32'(exp_uh));
        chk("upd_evict", 32'(upd_evict), 32'(exp_ue));
    endtask

    task automatic idle(input logic [29:0] r0, input logic [29:0] r1);
        cyc(1'b0, '0, 1'b0, 1'b0, r0, r1);
    endtask

    task automatic do_reset();
        reset = 1'b1; uv = 1'b0; flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_clear(1'b1);
        chk("rst_uh", 32'(upd_hit), 32'(0));
        chk("rst_ue", 32'(upd_evict), 32'(0));
    endtask

    function automatic logic [29:0] rnd_addr();
        logic [29:0] x;
        x = 30'($urandom_range(0, 31));
        if ($urandom_range(0, 7) == 0) x[29] = 1'b1;
        return x;
    endfunction

    initial begin
        do_reset();

        ra0 = 30'h10;
        #1;
        chk("rst_hit0", 32'(hit0), 32'(0));
        chk("rst_dout0", 32'(dout0), 32'(0));
        chk("rst_taken0", 32'(taken0), 32'(0));

        cyc(1'b1, 30'h10, 1'b1, 1'b0, 30'h10, 30'h10);
        idle(30'h10, 30'h10);
        chk("alloc_uh", 32'(upd_hit), 32'(0));
        chk("alloc_ue", 32'(upd_evict), 32'(0));
        idle(30'h10, 30'h10);
        chk("wk_hit0", 32'(hit0), 32'(1));
        chk("wk_dout0", 32'(dout0), 32'(2));
        chk("wk_taken0", 32'(taken0), 32'(1));
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 30'h10, 1'b1, 1'b0, 30'h10, 30'h10);
        idle(30'h10, 30'h10);
        chk("sat_uh", 32'(upd_hit), 32'(1));
        idle(30'h10, 30'h10);
        chk("sat_dout0", 32'(dout0), 32'(3));

        cyc(1'b1, 30'h20, 1'b0, 1'b0, 30'h10, 30'h20);
        idle(30'h10, 30'h20);
        idle(30'h10, 30'h20);
        chk("wn_dout1", 32'(dout1), 32'(1));
        chk("wn_taken1", 32'(taken1), 32'(0));
        cyc(1'b1, 30'h20, 1'b0, 1'b0, 30'h10, 30'h20);
        cyc(1'b1, 30'h20, 1'b0, 1'b0, 30'h10, 30'h20);
        idle(30'h10, 30'h20);
        idle(30'h10, 30'h20);
        chk("uf_hit1", 32'(hit1), 32'(1));
        chk("uf_dout1", 32'(dout1), 32'(0));

        do_reset();
        cyc(1'b1, 30'h08, 1'b1, 1'b0, 30'h08, 30'h10);
        cyc(1'b1, 30'h10, 1'b1, 1'b0, 30'h08, 30'h10);
        cyc(1'b1, 30'h18, 1'b1, 1'b0, 30'h08, 30'h10);
        chk("cf_ue2", 32'(upd_evict), 32'(0));
        idle(30'h10, 30'h18);
        chk("cf_ue3", 32'(upd_evict), 32'(1));
        idle(30'h10, 30'h18);
        chk("cf_hit10", 32'(hit0), 32'(1));
        chk("cf_hit18", 32'(hit1), 32'(1));
        ra0 = 30'h08;
        #1;
        chk("cf_miss08", 32'(hit0), 32'(0));

        cyc(1'b1, 30'h28, 1'b1, 1'b0, 30'h10, 30'h18);
        cyc(1'b1, 30'h30, 1'b1, 1'b1, 30'h10, 30'h18);
        idle(30'h30, 30'h28);
        idle(30'h30, 30'h10);
        chk("fl_miss30", 32'(hit0), 32'(0));
        chk("fl_miss10", 32'(hit1), 32'(0));

        cyc(1'b1, 30'h40, 1'b1, 1'b0, 30'h40, 30'h40);
        do_reset();
        idle(30'h40, 30'h40);
        idle(30'h40, 30'h40);
        chk("rq_miss40", 32'(hit0), 32'(0));
        chk("rq_uh", 32'(upd_hit), 32'(0));
        chk("rq_ue", 32'(upd_evict), 32'(0));

        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 3) != 0, rnd_addr(), 1'($urandom_range(0, 1)),
                $urandom_range(0, 63) == 0, rnd_addr(), rnd_addr());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
